// File: rtl/rfPhoenixMmupkg.sv
// Shared MMU/D-cache types: the cache line layout, the line-fill FSM states
// and the fill beat count.
package rfPhoenixMmupkg;

    // [255:0] line data, [256] valid bit.
    typedef logic [256:0] DCacheLine;

    localparam int DCACHE_FILL_BEATS = 4;

    typedef enum logic [1:0] {
        DCF_IDLE    = 2'd0,
        DCF_COLLECT = 2'd1,
        DCF_WRITE   = 2'd2
    } dcfill_state_t;

endpackage

// File: rtl/dcache_line_fill.sv
// D-cache line fill engine: gathers BEATS response beats into a line buffer
// and issues one full-line write (valid set) unless any beat flagged an error.
import rfPhoenixMmupkg::*;

module dcache_line_fill #(
    parameter int BEATS  = DCACHE_FILL_BEATS,
    parameter int BEAT_W = 64,
    parameter int ADR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADR_W-1:0]  req_adr,
    output logic              req_rdy,
    input  logic              beat_v,
    input  logic [BEAT_W-1:0] beat_dat,
    input  logic              beat_err,
    output logic              beat_rdy,
    output logic              wr,
    output logic [ADR_W-1:0]  wadr,
    output DCacheLine         wdat,
    output logic              busy,
    output logic [ADR_W-1:0]  busy_adr,
    output logic              done,
    output logic              err
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dcfill_state_t     state_q, state_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] buf_q, buf_d;
    logic              serr_q, serr_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              req_rdy_q, req_rdy_d;
    logic              beat_rdy_q, beat_rdy_d;

    // Next-state, datapath capture and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        serr_d  = serr_q;
        case (state_q)
            DCF_IDLE: begin
                if (req) begin
                    adr_d   = req_adr;
                    cnt_d   = '0;
                    serr_d  = 1'b0;
                    state_d = DCF_COLLECT;
                end else begin
                    state_d = DCF_IDLE;
                end
            end
            DCF_COLLECT: begin
                if (beat_v) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            buf_d[i*BEAT_W +: BEAT_W] = beat_dat;
                        end else begin
                            buf_d[i*BEAT_W +: BEAT_W] = buf_q[i*BEAT_W +: BEAT_W];
                        end
                    end
                    serr_d = serr_q | beat_err;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DCF_WRITE;
                    end else begin
                        state_d = DCF_COLLECT;
                    end
                end else begin
                    state_d = DCF_COLLECT;
                end
            end
            DCF_WRITE: begin
                state_d = DCF_IDLE;
            end
            default: begin
                state_d = DCF_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        wr_d       = (state_d == DCF_WRITE) && !serr_d;
        done_d     = (state_d == DCF_WRITE) && !serr_d;
        err_d      = (state_d == DCF_WRITE) && serr_d;
        busy_d     = (state_d != DCF_IDLE);
        req_rdy_d  = (state_d == DCF_IDLE);
        beat_rdy_d = (state_d == DCF_COLLECT);
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DCF_IDLE;
            adr_q      <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            serr_q     <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            req_rdy_q  <= 1'b1;
            beat_rdy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            serr_q     <= serr_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            req_rdy_q  <= req_rdy_d;
            beat_rdy_q <= beat_rdy_d;
        end
    end

    assign req_rdy  = req_rdy_q;
    assign beat_rdy = beat_rdy_q;
    assign wr       = wr_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign busy_adr = adr_q;
    assign wadr     = adr_q;
    assign wdat     = {1'b1, buf_q};

endmodule

// File: tb/tb_dcache_line_fill.sv
// Self-checking bench for dcache_line_fill: directed vector table, randomized
// fills against a line-level memory model, reset and back-to-back sequences.
module tb_dcache_line_fill;
    import rfPhoenixMmupkg::*;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 64;
    localparam int ADR_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [ADR_W-1:0]  req_adr;
    logic              req_rdy;
    logic              beat_v;
    logic [BEAT_W-1:0] beat_dat;
    logic              beat_err;
    logic              beat_rdy;
    logic              wr;
    logic [ADR_W-1:0]  wadr;
    DCacheLine         wdat;
    logic              busy;
    logic [ADR_W-1:0]  busy_adr;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    dcache_line_fill #(.BEATS(BEATS), .BEAT_W(BEAT_W), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_adr(req_adr), .req_rdy(req_rdy),
        .beat_v(beat_v), .beat_dat(beat_dat), .beat_err(beat_err), .beat_rdy(beat_rdy),
        .wr(wr), .wadr(wadr), .wdat(wdat), .busy(busy), .busy_adr(busy_adr),
        .done(done), .err(err)
    );

    // Line RAM the engine writes into, with a 1-cycle read port.
    DCacheLine        ram [1024];
    logic [ADR_W-1:0] radr = '0;
    DCacheLine        rdat;
    int               wr_seen = 0;
    always @(posedge clk) begin
        if (wr) begin
            ram[wadr] <= wdat;
            wr_seen   <= wr_seen + 1;
        end
        rdat <= ram[radr];
    end

    // Reference model: expected RAM contents, line by line.
    DCacheLine ref_mem   [1024];
    bit        ref_known [1024];
    int        exp_writes = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [255:0]     line;
        logic [3:0]       errm;
        int               gap;
        bit               exp_err;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!req_rdy && n < 20) begin
            step();
            n++;
        end
        chk("req_rdy_wait", req_rdy, 1'b1);
    endtask

    // One complete fill; gap < 0 picks a random 0..2 idle gap per beat.
    task automatic do_fill(input logic [ADR_W-1:0] a, input logic [255:0] line,
                           input logic [3:0] errm, input int gap, input bit exp_err);
        int g;
        wait_rdy();
        req = 1'b1;
        req_adr = a;
        step();
        req = 1'b0;
        chk("busy_accept", busy, 1'b1);
        chk("busy_adr_accept", busy_adr, a);
        chk("beat_rdy_accept", beat_rdy, 1'b1);
        chk("req_rdy_collect", req_rdy, 1'b0);
        for (int i = 0; i < BEATS; i++) begin
            beat_v   = 1'b1;
            beat_dat = line[i*BEAT_W +: BEAT_W];
            beat_err = errm[i];
            step();
            beat_v   = 1'b0;
            beat_err = 1'b0;
            if (i < BEATS - 1) begin
                g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
                repeat (g) begin
                    chk("busy_gap", busy, 1'b1);
                    chk("wr_gap", wr, 1'b0);
                    step();
                end
            end
        end
        chk("wr", wr, !exp_err);
        chk("done", done, !exp_err);
        chk("err", err, exp_err);
        chk("wadr", wadr, a);
        chk("busy_wr", busy, 1'b1);
        chk("busy_adr_wr", busy_adr, a);
        chk("req_rdy_wr", req_rdy, 1'b0);
        chk("beat_rdy_wr", beat_rdy, 1'b0);
        if (!exp_err) begin
            chk("wdat", wdat, {1'b1, line});
            ref_mem[a]   = {1'b1, line};
            ref_known[a] = 1'b1;
            exp_writes++;
        end
        step();
        chk("req_rdy_after", req_rdy, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("wr_after", wr, 1'b0);
        chk("done_after", done, 1'b0);
        chk("err_after", err, 1'b0);
        if (ref_known[a]) begin
            radr = a;
            step();
            chk("ram_read", rdat, ref_mem[a]);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] la, lb, cur;
        logic [3:0]   em;
        int           cyc, acc1, acc2, last1, bi, fill;
        bit           acc_b, acc_r;

        tbl[0] = '{10'h05A, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   4'b0000, 0, 1'b0};
        tbl[1] = '{10'h05A, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                   4'b0000, 2, 1'b0};
        tbl[2] = '{10'h123, {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                             64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
                   4'b0000, 1, 1'b0};
        tbl[3] = '{10'h123, {64'hAAAA_5555_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F,
                             64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0},
                   4'b0010, 1, 1'b1};
        tbl[4] = '{10'h000, {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                             64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001},
                   4'b1000, 0, 1'b1};

        rst = 1'b1; req = 1'b0; req_adr = '0;
        beat_v = 1'b0; beat_dat = '0; beat_err = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_wr", wr, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_beat_rdy", beat_rdy, 1'b0);
        chk("rst_busy_adr", busy_adr, 10'h000);
        chk("rst_wdat", wdat, {1'b1, 256'h0});
        rst = 1'b0;
        step();

        // Directed vectors: basic, gapped, overwrite, error-drop, last-beat error.
        for (int t = 0; t < 5; t++) begin
            do_fill(tbl[t].adr, tbl[t].line, tbl[t].errm, tbl[t].gap, tbl[t].exp_err);
        end

        // Reset after two beats, then a clean fill to the top index.
        wait_rdy();
        req = 1'b1;
        req_adr = 10'h3FF;
        step();
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            beat_v = 1'b1;
            beat_dat = 64'hBAD0_0000_0000_0000 | 64'(i);
            step();
        end
        beat_v = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_req_rdy", req_rdy, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wr", wr, 1'b0);
        chk("midrst_beat_rdy", beat_rdy, 1'b0);
        chk("midrst_wdat", wdat, {1'b1, 256'h0});
        step();
        chk("midrst_wr2", wr, 1'b0);
        do_fill(10'h3FF, rand_line(), 4'b0000, 0, 1'b0);

        // Back-to-back requests with req held and beats offered early.
        wait_rdy();
        la = rand_line();
        lb = rand_line();
        cyc = 0; acc1 = -1; acc2 = -1; last1 = -1; bi = 0; fill = 0;
        req = 1'b1;
        req_adr = 10'h001;
        while (fill < 2 && cyc < 60) begin
            cur = (fill == 0) ? la : lb;
            beat_v   = 1'b1;
            beat_dat = cur[bi*BEAT_W +: BEAT_W];
            beat_err = 1'b0;
            acc_b = beat_rdy && beat_v;
            acc_r = req && req_rdy;
            if (acc_r) begin
                if (acc1 < 0) acc1 = cyc;
                else          acc2 = cyc;
            end
            step();
            cyc++;
            if (acc_r && acc2 < 0) req_adr = 10'h002;
            if (acc_r && acc2 >= 0) req = 1'b0;
            if (acc_b) begin
                bi++;
                if (bi == BEATS) begin
                    bi = 0;
                    if (fill == 0) last1 = cyc - 1;
                    fill++;
                end
            end
        end
        beat_v = 1'b0;
        req = 1'b0;
        chk("b2b_fills", fill, 2);
        chk("b2b_wr", wr, 1'b1);
        chk("b2b_wadr", wadr, 10'h002);
        chk("b2b_accept_gap", acc2 - last1, 2);
        ref_mem[1] = {1'b1, la}; ref_known[1] = 1'b1;
        ref_mem[2] = {1'b1, lb}; ref_known[2] = 1'b1;
        exp_writes += 2;
        step();
        radr = 10'h001;
        step();
        chk("b2b_read1", rdat, ref_mem[1]);
        radr = 10'h002;
        step();
        chk("b2b_read2", rdat, ref_mem[2]);

        // Randomized fills against the line-level model.
        for (int n = 0; n < 30; n++) begin
            em = ($urandom_range(3, 0) == 0) ? (4'b0001 << $urandom_range(3, 0)) : 4'b0000;
            do_fill(10'($urandom_range(1023, 0)), rand_line(), em, -1, |em);
        end

        step();
        chk("write_count", wr_seen, exp_writes);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
